tube_host_initiator: RTL

TUBE_HOST_INITIATOR -- requirements
Module: tube_host_initiator

---
 rtl/tube_host_pkg.sv | 31 +++
 rtl/tube_host_initiator_if.sv | 32 +++
 rtl/tube_host_poll_timer.sv | 44 ++++
 rtl/tube_host_initiator.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tube_host_pkg.sv
// Shared types and helpers for the Tube host initiator: FSM states, response
// codes, status bit positions and the register-to-address mapping.
package tube_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_GAP,
    ST_XFER,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_TIMEOUT = 2'b01,
    RSP_ILLEGAL = 2'b10
  } rsp_err_e;

  localparam int STAT_AVAIL   = 7;
  localparam int STAT_NOTFULL = 6;

  localparam logic [2:0] REG_MAX = 3'd4;

  // Register n (1..4) lives at status 2n-2 / data 2n-1, i.e. {n-1, is_data};
  // register 0 is the control/status port at address 0.
  function automatic logic [2:0] tube_addr(input logic [2:0] reg_sel, input logic status);
    if (reg_sel == 3'd0) return 3'd0;
    return {reg_sel[1:0] - 2'd1, ~status};
  endfunction

endpackage

// File: rtl/tube_host_initiator_if.sv
// Bundle of the command/response handshake and the Tube host bus signals.
// master = the initiator side, slave = the command issuer / Tube side.
interface tube_host_initiator_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_reg;
  logic       cmd_write;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_err;
  logic [2:0] h_addr;
  logic       h_cs_b;
  logic       h_rdnw;
  logic [7:0] h_data_out;
  logic [7:0] h_data_in;
  logic       h_irq_b;

  modport master (
    input  cmd_valid, cmd_reg, cmd_write, cmd_wdata, h_data_in, h_irq_b,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output h_addr, h_cs_b, h_rdnw, h_data_out
  );

  modport slave (
    output cmd_valid, cmd_reg, cmd_write, cmd_wdata, h_data_in, h_irq_b,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  h_addr, h_cs_b, h_rdnw, h_data_out
  );

endinterface

// File: rtl/tube_host_poll_timer.sv
// Saturating 8-bit poll counter with limit compare, plus the inter-poll gap
// counter used by the Tube host initiator.
module tube_host_poll_timer #(
  parameter int POLL_LIMIT = 255,
  parameter int IDLE_GAP   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic poll_clr,
  input  logic poll_inc,
  input  logic gap_run,
  output logic poll_limit_hit,
  output logic gap_done
);

  localparam logic [7:0] LIMIT    = 8'(POLL_LIMIT);
  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

  logic [7:0] poll_cnt_q, poll_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;

  // NOTE: every combinational output is given a default before any branch, so no path can infer a latch.
  always_comb begin
    poll_cnt_d = poll_cnt_q;
    if (poll_clr) poll_cnt_d = 8'd0;
    if (poll_inc && (poll_cnt_d != 8'hFF)) poll_cnt_d = poll_cnt_d + 8'd1;
    gap_cnt_d = gap_run ? gap_cnt_q + 4'd1 : 4'd0;
  end

  // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt_q <= 8'd0;
      gap_cnt_q  <= 4'd0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign poll_limit_hit = (poll_cnt_q == LIMIT);
  assign gap_done       = (gap_cnt_q == GAP_LAST);

endmodule

// File: rtl/tube_host_initiator.sv
// Tube host-side initiator: turns single register commands into polled Tube
// bus cycles. Define TUBE_HOST_IRQ_WAIT_EN to make register-4 reads wait on h_irq_b.
module tube_host_initiator
  import tube_host_pkg::*;
#(
  parameter int POLL_LIMIT = 255,
  parameter int IDLE_GAP   = 1
) (
  input  logic       h_phi2,
  input  logic       h_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_reg,
  input  logic       cmd_write,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_err,
  output logic [2:0] h_addr,
  output logic       h_cs_b,
  output logic       h_rdnw,
  output logic [7:0] h_data_out,
  input  logic [7:0] h_data_in,
  input  logic       h_irq_b
);

  state_e     state_q, state_d;
  logic [2:0] cmd_reg_q, cmd_reg_d;
  logic       cmd_write_q, cmd_write_d;
  logic [7:0] cmd_wdata_q, cmd_wdata_d;
  logic       wait_mode_q, wait_mode_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  rsp_err_e   rsp_err_q, rsp_err_d;
  logic [2:0] h_addr_q, h_addr_d;
  logic       h_cs_b_q, h_cs_b_d;
  logic       h_rdnw_q, h_rdnw_d;
  logic [7:0] h_data_out_q, h_data_out_d;

  logic accept, poll_ready, poll_limit_hit, gap_done;
  logic irq_wait_req, irq_seen;

`ifdef TUBE_HOST_IRQ_WAIT_EN
  assign irq_wait_req = (cmd_reg == 3'd4) && !cmd_write;
  assign irq_seen     = !h_irq_b;
`else
  logic unused_irq;
  assign unused_irq   = h_irq_b;
  assign irq_wait_req = 1'b0;
  assign irq_seen     = 1'b0;
`endif

  assign poll_ready = cmd_write_q ? h_data_in[STAT_NOTFULL] : h_data_in[STAT_AVAIL];

  always_comb begin
    state_d     = state_q;
    cmd_reg_d   = cmd_reg_q;
    cmd_write_d = cmd_write_q;
    cmd_wdata_d = cmd_wdata_q;
    wait_mode_d = wait_mode_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    accept      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          accept      = 1'b1;
          cmd_reg_d   = cmd_reg;
          cmd_write_d = cmd_write;
          cmd_wdata_d = cmd_wdata;
          wait_mode_d = irq_wait_req;
          if (cmd_reg > REG_MAX) begin
            state_d    = ST_RESP;
            rsp_err_d  = RSP_ILLEGAL;
            rsp_data_d = 8'h00;
          end else if (cmd_reg == 3'd0) begin
            state_d = ST_XFER;
          end else if (irq_wait_req) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_POLL;
          end
        end
      end
      ST_POLL: begin
        if (poll_ready) begin
          state_d = ST_XFER;
        end else if (poll_limit_hit) begin
          state_d    = ST_RESP;
          rsp_err_d  = RSP_TIMEOUT;
          rsp_data_d = 8'h00;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (wait_mode_q) begin
          if (irq_seen) begin
            state_d = ST_XFER;
          end else if (poll_limit_hit) begin
            state_d    = ST_RESP;
            rsp_err_d  = RSP_TIMEOUT;
            rsp_data_d = 8'h00;
          end
        end else if (gap_done) begin
          state_d = ST_POLL;
        end
      end
      ST_XFER: begin
        state_d    = ST_RESP;
        rsp_err_d  = RSP_OK;
        rsp_data_d = cmd_write_q ? 8'h00 : h_data_in;
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);

    // Bus registers are loaded from the next state so each access is one full period.
    h_cs_b_d     = 1'b1;
    h_rdnw_d     = 1'b1;
    h_addr_d     = h_addr_q;
    h_data_out_d = h_data_out_q;
    if (state_d == ST_POLL) begin
      h_cs_b_d = 1'b0;
      h_addr_d = tube_addr(cmd_reg_d, 1'b1);
    end else if (state_d == ST_XFER) begin
      h_cs_b_d = 1'b0;
      h_rdnw_d = !cmd_write_d;
      h_addr_d = tube_addr(cmd_reg_d, 1'b0);
      if (cmd_write_d) h_data_out_d = cmd_wdata_d;
    end
  end

  always_ff @(posedge h_phi2 or posedge h_rst) begin
    if (h_rst) begin
      state_q      <= ST_IDLE;
      cmd_reg_q    <= 3'd0;
      cmd_write_q  <= 1'b0;
      cmd_wdata_q  <= 8'h00;
      wait_mode_q  <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 8'h00;
      rsp_err_q    <= RSP_OK;
      h_addr_q     <= 3'd0;
      h_cs_b_q     <= 1'b1;
      h_rdnw_q     <= 1'b1;
      h_data_out_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      cmd_reg_q    <= cmd_reg_d;
      cmd_write_q  <= cmd_write_d;
      cmd_wdata_q  <= cmd_wdata_d;
      wait_mode_q  <= wait_mode_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      h_addr_q     <= h_addr_d;
      h_cs_b_q     <= h_cs_b_d;
      h_rdnw_q     <= h_rdnw_d;
      h_data_out_q <= h_data_out_d;
    end
  end

  // Polls count on entry to POLL, or per waited cycle when waiting on the interrupt.
  tube_host_poll_timer #(
    .POLL_LIMIT(POLL_LIMIT),
    .IDLE_GAP  (IDLE_GAP)
  ) u_timer (
    .clk           (h_phi2),
    .rst           (h_rst),
    .poll_clr      (accept),
    .poll_inc      ((state_d == ST_POLL) || (wait_mode_d && (state_d == ST_GAP))),
    .gap_run       (state_q == ST_GAP),
    .poll_limit_hit(poll_limit_hit),
    .gap_done      (gap_done)
  );

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign h_addr     = h_addr_q;
  assign h_cs_b     = h_cs_b_q;
  assign h_rdnw     = h_rdnw_q;
  assign h_data_out = h_data_out_q;

endmodule
